// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with valid/ready on both sides, an optional skid entry
// that makes mem_ready a pure register output, synchronous flush, and a forwarding lookup.
module mem_wb_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int SKID           = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  logic                      mem_we,
    input  logic [REG_ADDR_WIDTH-1:0] mem_regDest,
    input  logic [DATA_WIDTH-1:0]     mem_value,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic                      wb_we,
    output logic [REG_ADDR_WIDTH-1:0] wb_regDest,
    output logic [DATA_WIDTH-1:0]     wb_value,
    input  logic [REG_ADDR_WIDTH-1:0] fwd_reg,
    output logic                      fwd_hit,
    output logic [DATA_WIDTH-1:0]     fwd_value,
    output logic [1:0]                occupancy
);

    logic                      r_m_valid, r_m_we;
    logic [REG_ADDR_WIDTH-1:0] r_m_reg;
    logic [DATA_WIDTH-1:0]     r_m_value;
    logic                      r_s_valid, r_s_we;
    logic [REG_ADDR_WIDTH-1:0] r_s_reg;
    logic [DATA_WIDTH-1:0]     r_s_value;

    logic                      w_m_valid_nxt, w_m_we_nxt;
    logic [REG_ADDR_WIDTH-1:0] w_m_reg_nxt;
    logic [DATA_WIDTH-1:0]     w_m_value_nxt;
    logic                      w_s_valid_nxt, w_s_we_nxt;
    logic [REG_ADDR_WIDTH-1:0] w_s_reg_nxt;
    logic [DATA_WIDTH-1:0]     w_s_value_nxt;

    logic w_accept, w_drain, w_in_we, w_s_hit, w_m_hit;

    // With SKID=0 the skid registers are never loaded and hold their reset value.
    assign mem_ready = (SKID != 0) ? !r_s_valid : (!r_m_valid || wb_ready);
    assign w_accept  = mem_valid && mem_ready;
    assign w_drain   = r_m_valid && wb_ready;
    // Register 0 is hard-wired, so an entry targeting it never writes.
    assign w_in_we   = mem_we && (mem_regDest != '0);

    // NOTE: every next-state signal defaults to "hold" first so no path leaves one unassigned (no latch).
    always_comb begin
        w_m_valid_nxt = r_m_valid;
        w_m_we_nxt    = r_m_we;
        w_m_reg_nxt   = r_m_reg;
        w_m_value_nxt = r_m_value;
        w_s_valid_nxt = r_s_valid;
        w_s_we_nxt    = r_s_we;
        w_s_reg_nxt   = r_s_reg;
        w_s_value_nxt = r_s_value;

        if (flush) begin
            w_m_valid_nxt = 1'b0;
            w_s_valid_nxt = 1'b0;
        end else if (SKID != 0) begin
            if (!r_m_valid || w_drain) begin
                if (r_s_valid) begin
                    w_m_valid_nxt = 1'b1;
                    w_m_we_nxt    = r_s_we;
                    w_m_reg_nxt   = r_s_reg;
                    w_m_value_nxt = r_s_value;
                    w_s_valid_nxt = 1'b0;
                end else if (w_accept) begin
                    w_m_valid_nxt = 1'b1;
                    w_m_we_nxt    = w_in_we;
                    w_m_reg_nxt   = mem_regDest;
                    w_m_value_nxt = mem_value;
                end else begin
                    w_m_valid_nxt = 1'b0;
                end
            end else if (w_accept) begin
                w_s_valid_nxt = 1'b1;
                w_s_we_nxt    = w_in_we;
                w_s_reg_nxt   = mem_regDest;
                w_s_value_nxt = mem_value;
            end
        end else begin
            if (w_accept) begin
                w_m_valid_nxt = 1'b1;
                w_m_we_nxt    = w_in_we;
                w_m_reg_nxt   = mem_regDest;
                w_m_value_nxt = mem_value;
            end else if (w_drain) begin
                w_m_valid_nxt = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m_valid <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_reg   <= '0;
            r_m_value <= '0;
            r_s_valid <= 1'b0;
            r_s_we    <= 1'b0;
            r_s_reg   <= '0;
            r_s_value <= '0;
        end else begin
            r_m_valid <= w_m_valid_nxt;
            r_m_we    <= w_m_we_nxt;
            r_m_reg   <= w_m_reg_nxt;
            r_m_value <= w_m_value_nxt;
            r_s_valid <= w_s_valid_nxt;
            r_s_we    <= w_s_we_nxt;
            r_s_reg   <= w_s_reg_nxt;
            r_s_value <= w_s_value_nxt;
        end
    end

    assign wb_valid   = r_m_valid;
    assign wb_we      = r_m_we;
    assign wb_regDest = r_m_reg;
    assign wb_value   = r_m_value;

    // The skid entry is the younger one, so it wins when both match.
    assign w_s_hit   = r_s_valid && r_s_we && (r_s_reg == fwd_reg) && (fwd_reg != '0);
    assign w_m_hit   = r_m_valid && r_m_we && (r_m_reg == fwd_reg) && (fwd_reg != '0);
    assign fwd_hit   = w_s_hit || w_m_hit;
    assign fwd_value = w_s_hit ? r_s_value : (w_m_hit ? r_m_value : '0);

    assign occupancy = {1'b0, r_m_valid} + {1'b0, r_s_valid};

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: one SKID=1 instance and one SKID=0 instance,
// each scenario task checks its own expected values inline.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          total = 0;
    int          bad = 0;

    logic        flush = 1'b0, mem_valid = 1'b0, mem_we = 1'b0, wb_ready = 1'b0;
    logic [4:0]  mem_reg = '0, fwd_reg = '0;
    logic [31:0] mem_value = '0;
    logic        mem_ready, wb_valid, wb_we, fwd_hit;
    logic [4:0]  wb_reg;
    logic [31:0] wb_value, fwd_value;
    logic [1:0]  occ;

    logic        flush0 = 1'b0, mem_valid0 = 1'b0, mem_we0 = 1'b0, wb_ready0 = 1'b0;
    logic [4:0]  mem_reg0 = '0, fwd_reg0 = '0;
    logic [31:0] mem_value0 = '0;
    logic        mem_ready0, wb_valid0, wb_we0, fwd_hit0;
    logic [4:0]  wb_reg0;
    logic [31:0] wb_value0, fwd_value0;
    logic [1:0]  occ0;

    always #5 clk = ~clk;

    mem_wb_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .SKID(1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_regDest(mem_reg), .mem_value(mem_value),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we),
        .wb_regDest(wb_reg), .wb_value(wb_value),
        .fwd_reg(fwd_reg), .fwd_hit(fwd_hit), .fwd_value(fwd_value),
        .occupancy(occ)
    );

    mem_wb_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .SKID(0)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush0),
        .mem_valid(mem_valid0), .mem_ready(mem_ready0), .mem_we(mem_we0),
        .mem_regDest(mem_reg0), .mem_value(mem_value0),
        .wb_valid(wb_valid0), .wb_ready(wb_ready0), .wb_we(wb_we0),
        .wb_regDest(wb_reg0), .wb_value(wb_value0),
        .fwd_reg(fwd_reg0), .fwd_hit(fwd_hit0), .fwd_value(fwd_value0),
        .occupancy(occ0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic v, input logic [4:0] r, input logic [31:0] val);
        mem_valid = v;
        mem_we    = 1'b1;
        mem_reg   = r;
        mem_value = val;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 5'($urandom_range(1, 31)), $urandom);
            mem_valid0 = 1'b1; mem_we0 = 1'b1; mem_reg0 = 5'd7; mem_value0 = $urandom;
            tick();
            total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rst_wb_valid got=%b want=0", wb_valid); end
            total++; if (wb_value !== 32'h0) begin bad++; $display("FAIL rst_wb_value got=%h want=0", wb_value); end
            total++; if (occ !== 2'd0) begin bad++; $display("FAIL rst_occ got=%0d want=0", occ); end
            total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL rst_mem_ready got=%b want=1", mem_ready); end
            total++; if (mem_ready0 !== 1'b1) begin bad++; $display("FAIL rst_mem_ready0 got=%b want=1", mem_ready0); end
        end
        send(1'b0, 5'd0, 32'h0);
        mem_valid0 = 1'b0;
        rst = 1'b1;
        tick();
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rel_wb_valid got=%b want=0", wb_valid); end
        total++; if (occ !== 2'd0) begin bad++; $display("FAIL rel_occ got=%0d want=0", occ); end
        total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL rel_mem_ready got=%b want=1", mem_ready); end
        total++; if (fwd_hit !== 1'b0 || fwd_value !== 32'h0) begin bad++; $display("FAIL rel_fwd got=%b/%h want=0/0", fwd_hit, fwd_value); end
        send(1'b1, 5'd3, 32'h11);
        tick();
        send(1'b0, 5'd0, 32'h0);
        total++; if (wb_valid !== 1'b1 || wb_reg !== 5'd3 || wb_value !== 32'h11 || wb_we !== 1'b1)
            begin bad++; $display("FAIL first_accept got=%b/%0d/%h/%b want=1/3/11/1", wb_valid, wb_reg, wb_value, wb_we); end
        wb_ready = 1'b1;
        tick();
        total++; if (occ !== 2'd0) begin bad++; $display("FAIL first_drain_occ got=%0d want=0", occ); end
    endtask

    task automatic test_streaming();
        wb_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            send(1'b1, 5'(i), 32'(i));
            #1;
            total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d] got=%b want=1", i, mem_ready); end
            tick();
            total++; if (wb_valid !== 1'b1 || wb_value !== 32'(i)) begin bad++; $display("FAIL stream_val[%0d] got=%b/%h want=1/%h", i, wb_valid, wb_value, i); end
            total++; if (occ !== 2'd1) begin bad++; $display("FAIL stream_occ[%0d] got=%0d want=1", i, occ); end
        end
        send(1'b0, 5'd0, 32'h0);
        tick();
        total++; if (wb_valid !== 1'b0 || occ !== 2'd0) begin bad++; $display("FAIL stream_end got=%b/%0d want=0/0", wb_valid, occ); end
    endtask

    task automatic test_back_pressure();
        wb_ready = 1'b0;
        send(1'b1, 5'd1, 32'hA);
        tick();
        total++; if (occ !== 2'd1 || mem_ready !== 1'b1) begin bad++; $display("FAIL bp_a got=%0d/%b want=1/1", occ, mem_ready); end
        send(1'b1, 5'd2, 32'hB);
        tick();
        total++; if (occ !== 2'd2 || mem_ready !== 1'b0) begin bad++; $display("FAIL bp_b got=%0d/%b want=2/0", occ, mem_ready); end
        total++; if (wb_value !== 32'hA) begin bad++; $display("FAIL bp_head got=%h want=a", wb_value); end
        send(1'b1, 5'd3, 32'hC);
        tick();
        total++; if (occ !== 2'd2 || mem_ready !== 1'b0 || wb_value !== 32'hA) begin bad++; $display("FAIL bp_hold got=%0d/%b/%h want=2/0/a", occ, mem_ready, wb_value); end
        wb_ready = 1'b1;
        tick();
        total++; if (wb_value !== 32'hB || occ !== 2'd1 || mem_ready !== 1'b1) begin bad++; $display("FAIL bp_out_b got=%h/%0d/%b want=b/1/1", wb_value, occ, mem_ready); end
        tick();
        send(1'b0, 5'd0, 32'h0);
        total++; if (wb_valid !== 1'b1 || wb_value !== 32'hC || occ !== 2'd1) begin bad++; $display("FAIL bp_out_c got=%b/%h/%0d want=1/c/1", wb_valid, wb_value, occ); end
        tick();
        total++; if (wb_valid !== 1'b0 || occ !== 2'd0) begin bad++; $display("FAIL bp_empty got=%b/%0d want=0/0", wb_valid, occ); end
    endtask

    task automatic test_flush();
        wb_ready = 1'b0;
        send(1'b1, 5'd4, 32'h21); tick();
        send(1'b1, 5'd5, 32'h22); tick();
        total++; if (occ !== 2'd2) begin bad++; $display("FAIL fl_pre_occ got=%0d want=2", occ); end
        send(1'b1, 5'd6, 32'h99);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        send(1'b0, 5'd0, 32'h0);
        total++; if (wb_valid !== 1'b0 || occ !== 2'd0 || mem_ready !== 1'b1) begin bad++; $display("FAIL fl_full got=%b/%0d/%b want=0/0/1", wb_valid, occ, mem_ready); end
        total++; if (wb_value !== 32'h21) begin bad++; $display("FAIL fl_data_kept got=%h want=21", wb_value); end
        send(1'b1, 5'd7, 32'h31); tick();
        send(1'b1, 5'd8, 32'h77);
        #1;
        total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL fl_ready_in_flush got=%b want=1", mem_ready); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        send(1'b0, 5'd0, 32'h0);
        wb_ready = 1'b1;
        total++; if (occ !== 2'd0) begin bad++; $display("FAIL fl_single_occ got=%0d want=0", occ); end
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL fl_ghost[%0d] got=%b/%h want=0", i, wb_valid, wb_value); end
        end
    endtask

    task automatic test_forwarding();
        wb_ready = 1'b0;
        fwd_reg  = 5'd5;
        send(1'b1, 5'd5, 32'h100); tick();
        total++; if (fwd_hit !== 1'b1 || fwd_value !== 32'h100) begin bad++; $display("FAIL fwd_m got=%b/%h want=1/100", fwd_hit, fwd_value); end
        send(1'b1, 5'd5, 32'h200); tick();
        send(1'b0, 5'd0, 32'h0);
        total++; if (fwd_hit !== 1'b1 || fwd_value !== 32'h200) begin bad++; $display("FAIL fwd_s_wins got=%b/%h want=1/200", fwd_hit, fwd_value); end
        fwd_reg = 5'd6;
        #1;
        total++; if (fwd_hit !== 1'b0 || fwd_value !== 32'h0) begin bad++; $display("FAIL fwd_miss got=%b/%h want=0/0", fwd_hit, fwd_value); end
        wb_ready = 1'b1;
        tick(); tick();
        total++; if (occ !== 2'd0) begin bad++; $display("FAIL fwd_drain_occ got=%0d want=0", occ); end
        wb_ready = 1'b0;
        send(1'b1, 5'd0, 32'h55); tick();
        send(1'b0, 5'd0, 32'h0);
        fwd_reg = 5'd0;
        #1;
        total++; if (wb_valid !== 1'b1 || wb_we !== 1'b0 || wb_value !== 32'h55) begin bad++; $display("FAIL fwd_r0_we got=%b/%b/%h want=1/0/55", wb_valid, wb_we, wb_value); end
        total++; if (fwd_hit !== 1'b0) begin bad++; $display("FAIL fwd_r0_hit got=%b want=0", fwd_hit); end
        wb_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_transfer();
        wb_ready = 1'b0;
        send(1'b1, 5'd9, 32'h41); tick();
        send(1'b1, 5'd10, 32'h42); tick();
        send(1'b0, 5'd0, 32'h0);
        rst = 1'b0;
        #1;
        total++; if (occ !== 2'd0 || wb_valid !== 1'b0 || wb_value !== 32'h0 || mem_ready !== 1'b1)
            begin bad++; $display("FAIL rst_mid got=%0d/%b/%h/%b want=0/0/0/1", occ, wb_valid, wb_value, mem_ready); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_no_skid();
        wb_ready0 = 1'b0;
        mem_valid0 = 1'b1; mem_we0 = 1'b1; mem_reg0 = 5'd2; mem_value0 = 32'h31;
        tick();
        mem_valid0 = 1'b0;
        #1;
        total++; if (mem_ready0 !== 1'b0 || occ0 !== 2'd1) begin bad++; $display("FAIL ns_stall got=%b/%0d want=0/1", mem_ready0, occ0); end
        tick();
        total++; if (wb_value0 !== 32'h31 || mem_ready0 !== 1'b0) begin bad++; $display("FAIL ns_hold got=%h/%b want=31/0", wb_value0, mem_ready0); end
        wb_ready0 = 1'b1;
        #1;
        total++; if (mem_ready0 !== 1'b1) begin bad++; $display("FAIL ns_comb_ready got=%b want=1", mem_ready0); end
        mem_valid0 = 1'b1; mem_reg0 = 5'd3; mem_value0 = 32'h32;
        tick();
        mem_valid0 = 1'b0;
        total++; if (occ0 !== 2'd1 || wb_value0 !== 32'h32) begin bad++; $display("FAIL ns_swap got=%0d/%h want=1/32", occ0, wb_value0); end
        tick();
        total++; if (occ0 !== 2'd0 || wb_valid0 !== 1'b0) begin bad++; $display("FAIL ns_empty got=%0d/%b want=0/0", occ0, wb_valid0); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_forwarding();
        test_reset_mid_transfer();
        test_no_skid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Parametrised, elastic MEM/WB pipeline register with a valid/ready handshake on both sides.
- Optional skid entry so the stall path is fully registered.
- Synchronous flush.
- Combinational forwarding lookup of in-flight writebacks for the ID/EX hazard unit.
- Sits between the MEM stage and the register-file write port.

Parameters:
- DATA_WIDTH, 32, width of writeback value
- REG_ADDR_WIDTH, 5, width of destination register index
- SKID, 1, 1 = two-entry (main + skid) registered-ready stage; 0 = single entry with combinational ready

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous kill of all held entries
- mem_valid  in  1  MEM stage presents an entry
- mem_ready  out  1  stage can accept this cycle
- mem_we  in  1  entry writes the register file
- mem_regDest  in  REG_ADDR_WIDTH  destination register
- mem_value  in  DATA_WIDTH  writeback data
- wb_valid  out  1  entry presented to WB
- wb_ready  in  1  WB consumes this cycle
- wb_we  out  1  write enable of presented entry
- wb_regDest  out  REG_ADDR_WIDTH  destination of presented entry
- wb_value  out  DATA_WIDTH  data of presented entry
- fwd_reg  in  REG_ADDR_WIDTH  register queried by hazard unit
- fwd_hit  out  1  an in-flight entry writes fwd_reg
- fwd_value  out  DATA_WIDTH  youngest matching value
- occupancy  out  2  number of valid entries (0..2)

Behaviour:
- State: main entry M (valid, we, regDest, value); skid entry S exists only when SKID=1. The wb_* outputs are driven directly from M.
- Reset (rst low, asynchronous, any time):
  - M.valid = S.valid = 0; all data, we and regDest fields = 0.
  - Outputs: wb_valid=0, wb_we=0, wb_regDest=0, wb_value=0, mem_ready=1 (SKID=1) or 1 (SKID=0, since M is empty), fwd_hit=0, fwd_value=0, occupancy=0.
  - Reset mid-transfer discards both entries.
- Handshakes:
  - accept = mem_valid & mem_ready; drain = wb_valid & wb_ready.
  - mem_ready:
    - SKID=1: mem_ready = !S.valid, a pure register output.
    - SKID=0: mem_ready = !M.valid | wb_ready (combinational).
- Write-enable normalisation: an accepted entry with mem_regDest==0 is stored with we=0. The value is still stored.
- Next-state (SKID=1), evaluated each edge when flush=0:
  - M empty: accept loads M. S stays empty.
  - M full, drain, S empty: accept loads M; with no accept, M.valid=0.
  - M full, drain, S full: M<=S, S.valid=0. No accept is possible because mem_ready=0.
  - M full, no drain, accept: incoming entry loads S, so mem_ready=0 next cycle.
  - M full, no drain, no accept: hold.
- Next-state (SKID=0):
  - accept loads M.
  - drain without accept clears M.valid.
  - Otherwise hold.
- Ordering: entries leave WB strictly in acceptance order; no entry is duplicated or dropped except by flush or reset.
- Latency: an accepted entry appears on wb_* the next cycle when M is empty or drains that cycle; otherwise once the older entry drains.
- Flush (synchronous, highest priority after reset):
  - Next cycle M.valid=S.valid=0.
  - A same-cycle accept is discarded.
  - A same-cycle drain still counts as consumed by WB.
  - Data fields are left unchanged.
  - mem_ready may be 1 during the flush cycle; the accepted entry is still dropped.
- Forwarding (combinational):
  - fwd_hit = (S.valid & S.we & S.regDest==fwd_reg) | (M.valid & M.we & M.regDest==fwd_reg).
  - fwd_value = S.value if S matches, else M.value if M matches, else 0. S is younger and wins.
  - fwd_reg==0 never hits.
- occupancy = M.valid + S.valid, combinational from state.

Test Plan:
- Reset:
  - Stimulus: hold rst low with mem_valid=1 and random data, then release.
  - Response: wb_valid=0, wb_value=0, occupancy=0, mem_ready=1 throughout and one cycle after release; first accept (regDest=3, value=0x11) appears on wb_* next cycle.
- Streaming:
  - Stimulus: wb_ready=1, 8 back-to-back entries with values 1..8.
  - Response: wb_value 1..8 on consecutive cycles starting one cycle after the first accept; mem_ready stays 1; occupancy never exceeds 1.
- Backpressure, SKID=1:
  - Stimulus: wb_ready=0, send A=0xA, B=0xB, C=0xC.
  - Response: A in M, B in S, mem_ready=0 the cycle after B is accepted, C held by MEM; occupancy=2.
  - Stimulus: raise wb_ready.
  - Response: output order A, B, C with no loss.
- Flush:
  - Stimulus: occupancy=2, then assert flush with mem_valid=1 and wb_ready=0.
  - Response: next cycle wb_valid=0, occupancy=0, mem_ready=1; the flushed-cycle entry never appears on wb_*.
- Forwarding:
  - Stimulus: M={r5, 0x100}, S={r5, 0x200}, fwd_reg=5.
  - Response: fwd_hit=1, fwd_value=0x200.
  - Stimulus: fwd_reg=6.
  - Response: fwd_hit=0.
  - Stimulus: accept regDest=0, we=1.
  - Response: wb_we=0; fwd_reg=0 gives fwd_hit=0.
- SKID=0 variant:
  - Stimulus: M full, wb_ready=0.
  - Response: mem_ready=0 in the same cycle.
  - Stimulus: raise wb_ready.
  - Response: mem_ready=1 combinationally; a simultaneous accept and drain keeps occupancy=1.
